// File: rtl/pipe_skid_chain.sv
// Elastic valid/ready pipeline of STAGES cascaded stages, each optionally with a skid entry.
// Hazard stall freezes both chain ends; flush drops every held entry.
//
// state    | meaning (per stage, SKID=1)
// ST_EMPTY | no entry held
// ST_ONE   | main entry valid, skid free
// ST_FULL  | main and skid valid, stage in_ready low
module pipe_skid_chain #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 1,
    parameter int SKID   = 1,
    localparam int DEPTH = STAGES * (SKID + 1),
    localparam int OCC_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    input  logic             stall,
    input  logic             flush,
    output logic [OCC_W-1:0] occupancy
);

    localparam logic [1:0] ST_EMPTY = 2'b00;
    localparam logic [1:0] ST_ONE   = 2'b10;
    localparam logic [1:0] ST_FULL  = 2'b11;

    logic [STAGES-1:0] m_q, m_d;
    logic [STAGES-1:0] s_q, s_d;
    logic [WIDTH-1:0]  main_q [STAGES];
    logic [WIDTH-1:0]  main_d [STAGES];
    logic [WIDTH-1:0]  skid_q [STAGES];
    logic [WIDTH-1:0]  skid_d [STAGES];
    logic [OCC_W-1:0]  occ_q, occ_d;

    logic [STAGES-1:0] up_vld, up_rdy, dn_rdy, acc, emt;
    logic [WIDTH-1:0]  up_data [STAGES];

    // Ready walks from the output back to the input; only SKID=0 makes it combinational.
    always_comb begin : ready_chain
        logic nxt;
        nxt    = out_ready & ~stall;
        up_rdy = '0;
        dn_rdy = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            dn_rdy[k] = nxt;
            if (SKID != 0) begin
                up_rdy[k] = ~s_q[k];
            end else begin
                up_rdy[k] = ~m_q[k] | nxt;
            end
            nxt = up_rdy[k];
        end
    end

    always_comb begin : valid_chain
        up_vld     = '0;
        up_vld[0]  = in_valid & ~stall;
        up_data[0] = in_data;
        for (int k = 1; k < STAGES; k++) begin
            up_vld[k]  = m_q[k-1];
            up_data[k] = main_q[k-1];
        end
        acc = up_vld & up_rdy;
        emt = m_q & dn_rdy;
    end

    always_comb begin : stage_next
        m_d    = m_q;
        s_d    = s_q;
        main_d = main_q;
        skid_d = skid_q;
        for (int k = 0; k < STAGES; k++) begin
            if (flush) begin
                m_d[k] = 1'b0;
                s_d[k] = 1'b0;
            end else if (SKID != 0) begin
                case ({m_q[k], s_q[k]})
                    ST_EMPTY: begin
                        if (acc[k]) begin
                            m_d[k]    = 1'b1;
                            main_d[k] = up_data[k];
                        end
                    end
                    ST_ONE: begin
                        if (acc[k] && emt[k]) begin
                            main_d[k] = up_data[k];
                        end else if (acc[k]) begin
                            s_d[k]    = 1'b1;
                            skid_d[k] = up_data[k];
                        end else if (emt[k]) begin
                            m_d[k] = 1'b0;
                        end
                    end
                    ST_FULL: begin
                        if (emt[k]) begin
                            s_d[k]    = 1'b0;
                            main_d[k] = skid_q[k];
                        end
                    end
                    default: begin
                        m_d[k] = 1'b0;
                        s_d[k] = 1'b0;
                    end
                endcase
            end else begin
                if (acc[k]) begin
                    m_d[k]    = 1'b1;
                    main_d[k] = up_data[k];
                end else if (emt[k]) begin
                    m_d[k] = 1'b0;
                end
            end
        end
    end

    always_comb begin : occ_next
        if (flush) begin
            occ_d = '0;
        end else begin
            occ_d = occ_q + OCC_W'(acc[0]) - OCC_W'(emt[STAGES-1]);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_q   <= '0;
            s_q   <= '0;
            occ_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                main_q[k] <= '0;
                skid_q[k] <= '0;
            end
        end else begin
            m_q    <= m_d;
            s_q    <= s_d;
            occ_q  <= occ_d;
            main_q <= main_d;
            skid_q <= skid_d;
        end
    end

    assign in_ready  = up_rdy[0] & ~stall;
    assign out_valid = m_q[STAGES-1] & ~stall;
    assign out_data  = main_q[STAGES-1];
    assign occupancy = occ_q;

endmodule
